ctrl_pipe: RTL and testbench



---
 rtl/ctrl_pkg.sv | 98 +++++++++
 rtl/ctrl_decode.sv | 146 ++++++++++++++
 rtl/ctrl_pipe.sv | 123 ++++++++++++
 tb/tb_ctrl_pipe.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the decode pipeline register: opcodes,
// control-field encodings, the control bundle layout and its safe value.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam int CNT_W = 6;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_NOP  = 4'b1001,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  typedef enum logic [2:0] {
    MEM_LB  = 3'b000,
    MEM_LH  = 3'b001,
    MEM_LW  = 3'b010,
    MEM_LBU = 3'b011,
    MEM_LHU = 3'b100,
    MEM_SB  = 3'b101,
    MEM_SH  = 3'b110,
    MEM_SW  = 3'b111
  } mem_ctrl_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b01,
    WB_PC4 = 2'b10,
    WB_MEM = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,
    ST_FULL   = 2'b01,
    ST_MDBUSY = 2'b10
  } state_e;

  typedef struct packed {
    logic      reg_wr;
    logic      mem_rd;
    logic      mem_wr;
    logic      alu_s1;
    logic      alu_s2;
    logic      do_jump;
    logic      do_branch;
    logic      md_en;
    logic      illegal;
    wb_sel_e   wb;
    alu_op_e   alu_op;
    mem_ctrl_e mem_ctrl;
    logic [2:0] branch_ctrl;
    logic [2:0] md_op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t SAFE_BUNDLE = '{
    reg_wr:      1'b0,
    mem_rd:      1'b0,
    mem_wr:      1'b0,
    alu_s1:      1'b0,
    alu_s2:      1'b0,
    do_jump:     1'b0,
    do_branch:   1'b0,
    md_en:       1'b0,
    illegal:     1'b0,
    wb:          WB_MEM,
    alu_op:      ALU_NOP,
    mem_ctrl:    MEM_LB,
    branch_ctrl: 3'b000,
    md_op:       3'b000,
    rd:          5'd0,
    rs1:         5'd0,
    rs2:         5'd0
  };

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational RV32I(+M) main decoder: raw instruction to control bundle.
// Illegal encodings collapse to the safe bundle with the illegal flag raised.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit EN_M = 1'b1
) (
  input  logic [31:0]  instr,
  output ctrl_bundle_t bundle
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       ill;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    // NOTE: every field gets a default before the case so no latch is inferred.
    bundle     = SAFE_BUNDLE;
    ill        = 1'b0;
    bundle.rd  = instr[11:7];
    bundle.rs1 = instr[19:15];
    bundle.rs2 = instr[24:20];

    case (opcode)
      OP_R: begin
        bundle.reg_wr = 1'b1;
        bundle.wb     = WB_ALU;
        bundle.alu_s1 = 1'b1;
        bundle.alu_s2 = 1'b1;
        case (f7)
          F7_BASE: bundle.alu_op = alu_op_e'({1'b0, f3});
          F7_ALT: begin
            if (f3 == 3'b000)      bundle.alu_op = ALU_SUB;
            else if (f3 == 3'b101) bundle.alu_op = ALU_SRA;
            else                   ill = 1'b1;
          end
          F7_MULDIV: begin
            // Mul/div ops leave the ALU idle; the mul/div unit does the work.
            if (EN_M) begin
              bundle.md_en = 1'b1;
              bundle.md_op = f3;
            end else begin
              ill = 1'b1;
            end
          end
          default: ill = 1'b1;
        endcase
      end

      OP_IMM: begin
        bundle.reg_wr = 1'b1;
        bundle.wb     = WB_ALU;
        bundle.alu_s1 = 1'b1;
        bundle.alu_op = alu_op_e'({1'b0, f3});
        if (f3 == 3'b001 && f7 != F7_BASE) ill = 1'b1;
        if (f3 == 3'b101) begin
          if (f7 == F7_ALT)        bundle.alu_op = ALU_SRA;
          else if (f7 != F7_BASE)  ill = 1'b1;
        end
      end

      OP_LOAD: begin
        bundle.reg_wr = 1'b1;
        bundle.mem_rd = 1'b1;
        bundle.wb     = WB_MEM;
        bundle.alu_s1 = 1'b1;
        bundle.alu_op = ALU_ADD;
        case (f3)
          3'b000:  bundle.mem_ctrl = MEM_LB;
          3'b001:  bundle.mem_ctrl = MEM_LH;
          3'b010:  bundle.mem_ctrl = MEM_LW;
          3'b100:  bundle.mem_ctrl = MEM_LBU;
          3'b101:  bundle.mem_ctrl = MEM_LHU;
          default: ill = 1'b1;
        endcase
      end

      OP_STORE: begin
        bundle.mem_wr = 1'b1;
        bundle.alu_s1 = 1'b1;
        bundle.alu_op = ALU_ADD;
        case (f3)
          3'b000:  bundle.mem_ctrl = MEM_SB;
          3'b001:  bundle.mem_ctrl = MEM_SH;
          3'b010:  bundle.mem_ctrl = MEM_SW;
          default: ill = 1'b1;
        endcase
      end

      OP_BRANCH: begin
        bundle.do_branch   = 1'b1;
        bundle.branch_ctrl = f3;
        bundle.alu_s1      = 1'b1;
        bundle.alu_s2      = 1'b1;
        if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
      end

      OP_LUI: begin
        // LUI is executed as 0 + imm, so rs1 is forced to x0.
        bundle.reg_wr = 1'b1;
        bundle.wb     = WB_ALU;
        bundle.alu_s1 = 1'b1;
        bundle.rs1    = 5'd0;
        bundle.alu_op = ALU_ADD;
      end

      OP_AUIPC: begin
        bundle.reg_wr = 1'b1;
        bundle.wb     = WB_ALU;
        bundle.alu_op = ALU_ADD;
      end

      OP_JAL: begin
        bundle.reg_wr  = 1'b1;
        bundle.wb      = WB_PC4;
        bundle.do_jump = 1'b1;
        bundle.alu_op  = ALU_ADD;
      end

      OP_JALR: begin
        bundle.reg_wr  = 1'b1;
        bundle.wb      = WB_PC4;
        bundle.do_jump = 1'b1;
        bundle.alu_s1  = 1'b1;
        bundle.alu_op  = ALU_ADD;
        if (f3 != 3'b000) ill = 1'b1;
      end

      default: ill = 1'b1;
    endcase

    if (ill) begin
      bundle         = SAFE_BUNDLE;
      bundle.illegal = 1'b1;
      bundle.rd      = instr[11:7];
      bundle.rs1     = instr[19:15];
      bundle.rs2     = instr[24:20];
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Decode pipeline register between fetch and execute: valid/ready handshake,
// flush, and a structural stall while the single mul/div unit is occupied.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter bit          EN_M          = 1'b1,
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        regWR,
  output logic        memRD,
  output logic        memWR,
  output logic        aluS1,
  output logic        aluS2,
  output logic        doJump,
  output logic        doBranch,
  output logic        mdEn,
  output logic        illegal,
  output logic [1:0]  wbCtrl,
  output logic [3:0]  aluOp,
  output logic [2:0]  branchCtrl,
  output logic [2:0]  memCtrl,
  output logic [2:0]  mdOp,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  localparam bit MD_STALLS = (MULDIV_CYCLES > 1);
  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  ctrl_bundle_t dec;
  ctrl_bundle_t held;
  state_e       state;
  logic [CNT_W-1:0] cnt;
  logic         full;
  logic         md_block;
  logic         accept;
  logic         consume;

  ctrl_decode #(.EN_M(EN_M)) u_decode (
    .instr  (instr),
    .bundle (dec)
  );

  assign full    = (state == ST_FULL);
  // A mul/div bundle leaving the stage takes the unit, so nothing new may
  // enter on that same edge; the slot stays empty until the unit frees up.
  assign md_block = full && held.md_en && MD_STALLS;
  assign in_ready = !rst && !flush && (state != ST_MDBUSY)
                  && (!full || out_ready) && !md_block;
  assign accept   = in_valid && in_ready;
  assign consume  = full && out_ready;

  // NOTE: all state here is sequential and uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= ST_EMPTY;
      cnt   <= '0;
      held  <= SAFE_BUNDLE;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            held  <= dec;
            state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (consume) begin
            if (held.md_en && MD_STALLS) begin
              state <= ST_MDBUSY;
              cnt   <= MD_LOAD;
            end else if (accept) begin
              held  <= dec;
            end else begin
              state <= ST_EMPTY;
            end
          end
        end
        ST_MDBUSY: begin
          if (cnt == CNT_W'(1)) begin
            state <= ST_EMPTY;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= ST_EMPTY;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign out_valid  = full;
  assign regWR      = held.reg_wr;
  assign memRD      = held.mem_rd;
  assign memWR      = held.mem_wr;
  assign aluS1      = held.alu_s1;
  assign aluS2      = held.alu_s2;
  assign doJump     = held.do_jump;
  assign doBranch   = held.do_branch;
  assign mdEn       = held.md_en;
  assign illegal    = held.illegal;
  assign wbCtrl     = held.wb;
  assign aluOp      = held.alu_op;
  assign branchCtrl = held.branch_ctrl;
  assign memCtrl    = held.mem_ctrl;
  assign mdOp       = held.md_op;
  assign rd         = held.rd;
  assign rs1        = held.rs1;
  assign rs2        = held.rs2;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed self-checking bench for ctrl_pipe with a scoreboard of expected
// bundles; a second instance with EN_M=0 shares the stimulus.
module tb_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] instr;

  logic in_ready, out_valid, regWR, memRD, memWR, aluS1, aluS2, doJump, doBranch, mdEn, illegal;
  logic [1:0] wbCtrl;
  logic [3:0] aluOp;
  logic [2:0] branchCtrl, memCtrl, mdOp;
  logic [4:0] rd, rs1, rs2;

  logic n_in_ready, n_out_valid, n_regWR, n_memRD, n_memWR, n_aluS1, n_aluS2, n_doJump;
  logic n_doBranch, n_mdEn, n_illegal;
  logic [1:0] n_wbCtrl;
  logic [3:0] n_aluOp;
  logic [2:0] n_branchCtrl, n_memCtrl, n_mdOp;
  logic [4:0] n_rd, n_rs1, n_rs2;

  always #5 clk = ~clk;

  ctrl_pipe #(.EN_M(1'b1), .MULDIV_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .regWR(regWR), .memRD(memRD), .memWR(memWR), .aluS1(aluS1), .aluS2(aluS2),
    .doJump(doJump), .doBranch(doBranch), .mdEn(mdEn), .illegal(illegal),
    .wbCtrl(wbCtrl), .aluOp(aluOp), .branchCtrl(branchCtrl), .memCtrl(memCtrl),
    .mdOp(mdOp), .rd(rd), .rs1(rs1), .rs2(rs2)
  );

  ctrl_pipe #(.EN_M(1'b0), .MULDIV_CYCLES(4)) dut_nom (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .instr(instr),
    .flush(flush), .out_valid(n_out_valid), .out_ready(out_ready),
    .regWR(n_regWR), .memRD(n_memRD), .memWR(n_memWR), .aluS1(n_aluS1), .aluS2(n_aluS2),
    .doJump(n_doJump), .doBranch(n_doBranch), .mdEn(n_mdEn), .illegal(n_illegal),
    .wbCtrl(n_wbCtrl), .aluOp(n_aluOp), .branchCtrl(n_branchCtrl), .memCtrl(n_memCtrl),
    .mdOp(n_mdOp), .rd(n_rd), .rs1(n_rs1), .rs2(n_rs2)
  );

  int errors = 0;
  int checks = 0;
  logic [38:0] sb_q[$];

  // Flag order: regWR memRD memWR aluS1 aluS2 doJump doBranch mdEn illegal.
  function automatic logic [38:0] mk(input logic [8:0] f, input logic [1:0] wb,
                                     input logic [3:0] alu, input logic [2:0] brc,
                                     input logic [2:0] mem, input logic [2:0] mdo,
                                     input logic [4:0] d, input logic [4:0] s1,
                                     input logic [4:0] s2);
    return {f, wb, alu, brc, mem, mdo, d, s1, s2};
  endfunction

  function automatic logic [38:0] observed();
    return {regWR, memRD, memWR, aluS1, aluS2, doJump, doBranch, mdEn, illegal,
            wbCtrl, aluOp, branchCtrl, memCtrl, mdOp, rd, rs1, rs2};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag);
    logic [38:0] e;
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check(tag, {25'd0, observed()}, {25'd0, e});
    end
  endtask

  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_SRAI = 32'h40315093;
  localparam logic [31:0] I_MUL  = 32'h023100B3;
  localparam logic [31:0] I_JALR = 32'h00000067;

  logic [38:0] e_add, e_srai, e_mul, e_jalr, e_safe;
  logic [31:0] t_instr[7];
  logic [38:0] t_exp[7];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    e_add  = mk(9'b100110000, 2'b01, 4'b0000, 3'b000, 3'b000, 3'b000, 5'd1, 5'd2, 5'd3);
    e_srai = mk(9'b100100000, 2'b01, 4'b1101, 3'b000, 3'b000, 3'b000, 5'd1, 5'd2, 5'd3);
    e_mul  = mk(9'b100110010, 2'b01, 4'b1001, 3'b000, 3'b000, 3'b000, 5'd1, 5'd2, 5'd3);
    e_jalr = mk(9'b100101000, 2'b10, 4'b0000, 3'b000, 3'b000, 3'b000, 5'd0, 5'd0, 5'd0);
    e_safe = mk(9'b000000000, 2'b11, 4'b1001, 3'b000, 3'b000, 3'b000, 5'd0, 5'd0, 5'd0);

    t_instr[0] = 32'h00832283; // lw x5,8(x6)
    t_exp[0]   = mk(9'b110100000, 2'b11, 4'b0000, 3'b000, 3'b010, 3'b000, 5'd5, 5'd6, 5'd8);
    t_instr[1] = 32'h00742223; // sw x7,4(x8)
    t_exp[1]   = mk(9'b001100000, 2'b11, 4'b0000, 3'b000, 3'b111, 3'b000, 5'd4, 5'd8, 5'd7);
    t_instr[2] = 32'h0020C063; // blt x1,x2,0
    t_exp[2]   = mk(9'b000110100, 2'b11, 4'b1001, 3'b100, 3'b000, 3'b000, 5'd0, 5'd1, 5'd2);
    t_instr[3] = 32'h123451B7; // lui x3,0x12345 (rs1 field 8 forced to 0)
    t_exp[3]   = mk(9'b100100000, 2'b01, 4'b0000, 3'b000, 3'b000, 3'b000, 5'd3, 5'd0, 5'd3);
    t_instr[4] = I_JALR;
    t_exp[4]   = e_jalr;
    t_instr[5] = 32'h0000307F; // opcode 1111111
    t_exp[5]   = mk(9'b000000001, 2'b11, 4'b1001, 3'b000, 3'b000, 3'b000, 5'd0, 5'd0, 5'd0);
    t_instr[6] = 32'h0020A063; // branch with f3=010
    t_exp[6]   = mk(9'b000000001, 2'b11, 4'b1001, 3'b000, 3'b000, 3'b000, 5'd0, 5'd1, 5'd2);

    // Reset
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; instr = '0;
    tick(); tick();
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b0; #1;
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_bundle", {25'd0, observed()}, {25'd0, e_safe});
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);

    // First accept and one-cycle latency
    out_ready = 1'b1; in_valid = 1'b1; instr = I_ADD; #1;
    check("add_in_ready", {63'd0, in_ready}, 64'd1);
    sb_q.push_back(e_add);
    tick(); in_valid = 1'b0; #1;
    check_out("add");
    tick();
    check("drain_valid", {63'd0, out_valid}, 64'd0);

    // Back-pressure: bundle held, no accept while stalled
    out_ready = 1'b0; in_valid = 1'b1; instr = I_SRAI; #1;
    check("srai_in_ready", {63'd0, in_ready}, 64'd1);
    sb_q.push_back(e_srai);
    tick(); instr = I_ADD; #1;
    for (int k = 0; k < 3; k++) begin
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_bundle", {25'd0, observed()}, {25'd0, sb_q[0]});
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
    end
    out_ready = 1'b1; #1;
    check("release_in_ready", {63'd0, in_ready}, 64'd1);
    check_out("srai");
    sb_q.push_back(e_add);
    tick(); in_valid = 1'b0; #1;
    check_out("add_after_stall");
    tick();

    // Back-to-back throughput across opcode classes and illegal encodings
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; instr = t_instr[i]; #1;
      if (i > 0) check_out($sformatf("thru%0d", i - 1));
      check($sformatf("thru_ready%0d", i), {63'd0, in_ready}, 64'd1);
      sb_q.push_back(t_exp[i]);
      tick();
    end
    in_valid = 1'b0; #1;
    check_out("thru6");
    tick();

    // Mul/div stall: consumed at edge N, next accept at N+4
    in_valid = 1'b1; instr = I_MUL; #1;
    check("mul_in_ready", {63'd0, in_ready}, 64'd1);
    sb_q.push_back(e_mul);
    tick(); in_valid = 1'b0; #1;
    check("nom_mul_bundle", {56'd0, n_out_valid, n_illegal, n_mdEn, n_regWR, n_aluOp},
          {56'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1001});
    check_out("mul");
    tick();
    check("md_busy_ready0", {63'd0, in_ready}, 64'd0);
    check("md_busy_valid", {63'd0, out_valid}, 64'd0);
    check("nom_no_stall", {63'd0, n_in_ready}, 64'd1);
    tick();
    check("md_busy_ready1", {63'd0, in_ready}, 64'd0);
    tick();
    check("md_busy_ready2", {63'd0, in_ready}, 64'd0);
    tick();
    check("md_free_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; instr = I_ADD; #1;
    sb_q.push_back(e_add);
    tick(); in_valid = 1'b0; #1;
    check_out("add_after_mul");
    tick();

    // Flush beats simultaneous consume and accept
    out_ready = 1'b0; in_valid = 1'b1; instr = I_ADD; #1;
    tick();
    flush = 1'b1; out_ready = 1'b1; instr = t_instr[0]; #1;
    check("flush_in_ready", {63'd0, in_ready}, 64'd0);
    tick(); flush = 1'b0; in_valid = 1'b0; #1;
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_empty_ready", {63'd0, in_ready}, 64'd1);
    tick();
    check("flush_no_accept", {63'd0, out_valid}, 64'd0);

    // Flush aborts the mul/div stall
    in_valid = 1'b1; instr = I_MUL; #1;
    sb_q.push_back(e_mul);
    tick(); in_valid = 1'b0; #1;
    check_out("mul2");
    tick();
    check("md2_busy_ready", {63'd0, in_ready}, 64'd0);
    flush = 1'b1;
    tick(); flush = 1'b0; #1;
    check("flush_md_ready", {63'd0, in_ready}, 64'd1);
    check("flush_md_valid", {63'd0, out_valid}, 64'd0);
    in_valid = 1'b1; instr = I_JALR; #1;
    sb_q.push_back(e_jalr);
    tick(); in_valid = 1'b0; #1;
    check_out("jalr_after_flush");
    tick();

    // Reset in the middle of a mul/div stall
    in_valid = 1'b1; instr = I_MUL; #1;
    sb_q.push_back(e_mul);
    tick(); in_valid = 1'b0; #1;
    check_out("mul3");
    tick();
    check("md3_busy_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b1;
    tick();
    check("rst_cycle_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b0; #1;
    check("post_rst_ready", {63'd0, in_ready}, 64'd1);
    check("post_rst_valid", {63'd0, out_valid}, 64'd0);
    check("post_rst_bundle", {25'd0, observed()}, {25'd0, e_safe});

    check("sb_leftover", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
